// File: rtl/dna_stream_encoder.sv
// Streaming nucleotide encoder: packs 2-bit base codes for CH parallel channels
// into a LEN-deep buffer and hands the finished sequence downstream.
module dna_stream_encoder #(
   parameter  int LEN = 8,
   parameter  int CH  = 3,
   localparam int LW  = $clog2(LEN+1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CH*8-1:0]     in_char,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CH*LEN*2-1:0] out_seq,
   output logic [LW-1:0]       out_len,
   output logic [CH-1:0]       out_err,
   output logic                busy
);

   // state  | meaning
   // S_FILL | accepting beats, writing codes at index cnt
   // S_HOLD | sequence complete, presented until out_ready
   typedef enum logic {S_FILL = 1'b0, S_HOLD = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [LW-1:0]       cnt_q, cnt_d;
   logic [LW-1:0]       len_q, len_d;
   logic [CH*LEN*2-1:0] seq_q, seq_d;
   logic [CH-1:0]       err_q, err_d;
   logic                run_q, run_d;

   logic                accept;
   logic                term;
   logic                release_seq;
   logic [1:0]          code [CH];
   logic [CH-1:0]       bad;

   // {invalid, code}; unknown bytes encode as 00 and flag the channel
   function automatic logic [2:0] enc(input logic [7:0] c);
      case (c)
         8'h41, 8'h61: enc = 3'b000;
         8'h54, 8'h74: enc = 3'b001;
         8'h47, 8'h67: enc = 3'b010;
         8'h43, 8'h63: enc = 3'b011;
         default:      enc = 3'b100;
      endcase
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_FILL;
         cnt_q   <= '0;
         len_q   <= '0;
         seq_q   <= '0;
         err_q   <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         seq_q   <= seq_d;
         err_q   <= err_d;
         run_q   <= run_d;
      end
   end

   always_comb begin
      accept      = in_valid && in_ready;
      term        = accept && (in_last || (cnt_q == LW'(LEN-1)));
      release_seq = (state_q == S_HOLD) && out_ready;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FILL:  if (term) state_d = S_HOLD;
         S_HOLD:  if (out_ready) state_d = S_FILL;
         default: state_d = S_FILL;
      endcase
   end

   // run_q keeps in_ready low until the first edge after reset release
   always_comb begin
      in_ready  = (state_q == S_FILL) && run_q;
      out_valid = (state_q == S_HOLD);
      busy      = (state_q == S_HOLD) || (cnt_q != '0);
      out_seq   = seq_q;
      out_len   = len_q;
      out_err   = err_q;
   end

   always_comb begin
      for (int k = 0; k < CH; k++) begin
         {bad[k], code[k]} = enc(in_char[8*k +: 8]);
      end
   end

   always_comb begin
      run_d = 1'b1;
      seq_d = seq_q;
      cnt_d = cnt_q;
      len_d = len_q;
      err_d = err_q;
      if (release_seq) begin
         seq_d = '0;
         cnt_d = '0;
         len_d = '0;
         err_d = '0;
      end else if (accept) begin
         for (int k = 0; k < CH; k++) begin
            for (int i = 0; i < LEN; i++) begin
               if (LW'(i) == cnt_q) seq_d[2*(k*LEN+i) +: 2] = code[k];
            end
         end
         err_d = err_q | bad;
         cnt_d = cnt_q + 1'b1;
         if (term) len_d = cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_dna_stream_encoder.sv
// Directed bench for dna_stream_encoder with LEN=8, CH=3.
module tb_dna_stream_encoder;

   localparam int LEN = 8;
   localparam int CH  = 3;
   localparam int LW  = $clog2(LEN+1);

   logic                clk = 1'b0;
   logic                reset;
   logic                in_valid;
   logic                in_ready;
   logic [CH*8-1:0]     in_char;
   logic                in_last;
   logic                out_valid;
   logic                out_ready;
   logic [CH*LEN*2-1:0] out_seq;
   logic [LW-1:0]       out_len;
   logic [CH-1:0]       out_err;
   logic                busy;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   dna_stream_encoder #(.LEN(LEN), .CH(CH)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_seq(out_seq), .out_len(out_len), .out_err(out_err), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                        input logic last);
      in_char  = {c2, c1, c0};
      in_valid = 1'b1;
      in_last  = last;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   string s0, s1, s2;

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_char = '0;
      #3;
      check("rst_in_ready",  64'(in_ready),  64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy",      64'(busy),      64'd0);
      check("rst_out_len",   64'(out_len),   64'd0);
      check("rst_out_seq",   64'(out_seq),   64'd0);
      check("rst_out_err",   64'(out_err),   64'd0);
      #9 reset = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready", 64'(in_ready), 64'd1);

      // test 1: seven beats terminated by in_last
      s0 = "ATCGCGA"; s1 = "ATCCCAA"; s2 = "AATCCGA";
      for (int i = 0; i < 7; i++) begin
         drive(s0[i], s1[i], s2[i], i == 6);
         if (i == 5) begin
            check("t1_no_valid_yet", 64'(out_valid), 64'd0);
            check("t1_busy_fill",    64'(busy),      64'd1);
         end
      end
      check("t1_out_valid", 64'(out_valid), 64'd1);
      check("t1_out_len",   64'(out_len),   64'd7);
      check("t1_out_seq",   64'(out_seq),   64'h0BD0_03F4_0BB4);
      check("t1_out_err",   64'(out_err),   64'd0);
      check("t1_in_ready",  64'(in_ready),  64'd0);
      handshake();
      check("t1_rel_valid", 64'(out_valid), 64'd0);
      check("t1_rel_ready", 64'(in_ready),  64'd1);
      check("t1_rel_len",   64'(out_len),   64'd0);
      check("t1_rel_seq",   64'(out_seq),   64'd0);
      check("t1_rel_busy",  64'(busy),      64'd0);

      // test 2: eight beats fill the buffer, then HOLD ignores further beats
      s0 = "CCCCCCCC"; s1 = "tttttttt"; s2 = "GAGAGAGA";
      for (int i = 0; i < 8; i++) drive(s0[i], s1[i], s2[i], 1'b0);
      check("t2_out_valid", 64'(out_valid), 64'd1);
      check("t2_out_len",   64'(out_len),   64'd8);
      check("t2_in_ready",  64'(in_ready),  64'd0);
      check("t2_out_seq",   64'(out_seq),   64'h2222_5555_FFFF);
      in_char = {8'h43, 8'h43, 8'h43}; in_valid = 1'b1; in_last = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("t2_hold_seq",   64'(out_seq),   64'h2222_5555_FFFF);
         check("t2_hold_valid", 64'(out_valid), 64'd1);
      end
      check("t2_hold_len", 64'(out_len), 64'd8);
      in_valid = 1'b0; in_last = 1'b0;
      handshake();
      check("t2_rel_len", 64'(out_len), 64'd0);

      // test 3: invalid 'N' and lowercase 'g' on ch1, with an idle gap
      drive("A", "A", "A", 1'b0);
      drive("A", "T", "A", 1'b0);
      in_char = {8'h43, 8'h43, 8'h43}; in_last = 1'b1;
      @(posedge clk); #1;
      in_last = 1'b0;
      check("t3_gap_valid", 64'(out_valid), 64'd0);
      check("t3_gap_busy",  64'(busy),      64'd1);
      drive("A", "N", "A", 1'b0);
      check("t3_err_fill", 64'(out_err), 64'b010);
      drive("A", "g", "A", 1'b1);
      check("t3_out_len", 64'(out_len), 64'd4);
      check("t3_out_seq", 64'(out_seq), 64'h0000_0084_0000);
      check("t3_out_err", 64'(out_err), 64'b010);
      handshake();
      check("t3_err_clr", 64'(out_err), 64'd0);

      // test 4: single beat with out_ready already high
      out_ready = 1'b1;
      drive("C", "G", "T", 1'b1);
      check("t4_out_valid", 64'(out_valid), 64'd1);
      check("t4_out_len",   64'(out_len),   64'd1);
      check("t4_out_seq",   64'(out_seq),   64'h0001_0002_0003);
      @(posedge clk); #1;
      check("t4_valid_drop", 64'(out_valid), 64'd0);
      check("t4_in_ready",   64'(in_ready),  64'd1);
      out_ready = 1'b0;

      // test 5: in_last coinciding with index LEN-1
      for (int i = 0; i < 8; i++) drive("A", "A", "A", i == 7);
      check("t5_out_len",   64'(out_len),   64'd8);
      check("t5_out_valid", 64'(out_valid), 64'd1);
      handshake();
      drive("T", "T", "T", 1'b1);
      check("t5_next_len", 64'(out_len), 64'd1);
      check("t5_next_seq", 64'(out_seq), 64'h0001_0001_0001);
      handshake();

      // test 6: reset mid-FILL, then a fresh three-beat sequence
      for (int i = 0; i < 4; i++) drive("C", "C", "C", 1'b0);
      reset = 1'b0;
      #1;
      check("t6_rst_busy", 64'(busy),    64'd0);
      check("t6_rst_seq",  64'(out_seq), 64'd0);
      #9;
      check("t6_rst_ready", 64'(in_ready), 64'd0);
      #1 reset = 1'b1;
      @(posedge clk); #1;
      check("t6_ready_back", 64'(in_ready), 64'd1);
      drive("A", "T", "G", 1'b0);
      drive("T", "T", "G", 1'b0);
      drive("G", "T", "G", 1'b1);
      check("t6_out_len", 64'(out_len), 64'd3);
      check("t6_out_seq", 64'(out_seq), 64'h002A_0015_0024);
      check("t6_out_err", 64'(out_err), 64'd0);

      // reset during HOLD drops the sequence without waiting for a clock
      #2 reset = 1'b0;
      #1;
      check("t6_hold_rst_valid", 64'(out_valid), 64'd0);
      check("t6_hold_rst_len",   64'(out_len),   64'd0);
      check("t6_hold_rst_busy",  64'(busy),      64'd0);
      #10 reset = 1'b1;
      @(posedge clk); #1;
      check("t6_final_ready", 64'(in_ready), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dna_stream_encoder.md
Name: dna_stream_encoder

Overview:
- Sequential, parametrised successor to the combinational nucleotide encoder.
- Accepts one ASCII nucleotide character per channel per accepted beat over a valid/ready stream.
- Encodes each character to a 2-bit code and packs it into a per-channel sequence buffer of up to LEN bases.
- Presents the completed sequences as one packed word, with a length and per-channel invalid-character flags, to the downstream comparison/alignment logic under a second valid/ready handshake.

Parameters:
- LEN, 8, maximum bases per sequence (>=2).
- CH, 3, number of parallel sequence channels (>=1).
- LW, $clog2(LEN+1), width of the length field (derived; do not override).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset; asserted at 0.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_char  input  CH*8  ASCII character per channel; channel k at bits [8k+7:8k].
- in_last  input  1  this beat ends the current sequence.
- out_valid  output  1  packed sequence available.
- out_ready  input  1  downstream accepts the sequence.
- out_seq  output  CH*LEN*2  codes; channel k, base i at bits [2(k*LEN+i)+1 : 2(k*LEN+i)]; base 0 is the first accepted character.
- out_len  output  LW  number of valid bases (1..LEN).
- out_err  output  CH  sticky per-channel invalid-character flag for this sequence.
- busy  output  1  high while a sequence is partially filled (FILL with count>0) or held (HOLD).

Behaviour:
- Encoding: 'A'/'a'=00, 'T'/'t'=01, 'G'/'g'=10, 'C'/'c'=11. Any other byte encodes as 00 and sets out_err[k] for that channel until the sequence is released.
- State machine, two states:
  - FILL: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept condition: in_valid && in_ready. On an accepted beat:
  - Write the codes for all channels at index cnt.
  - cnt <= cnt+1.
  - Update out_err.
- FILL -> HOLD when an accepted beat has in_last=1 or writes index LEN-1. out_len <= cnt+1 on that same edge.
  - in_last on the first beat gives out_len=1.
  - in_last together with index LEN-1 is a single termination, not a double one.
- out_valid rises the cycle after the terminating beat (latency 1). out_seq, out_len and out_err are stable throughout HOLD.
- HOLD -> FILL on out_valid && out_ready. On that edge:
  - Buffer cleared to all zeros.
  - cnt=0.
  - out_err=0.
  - out_len=0.
  - in_ready returns to 1 the next cycle; there is no same-cycle pass-through.
- Unwritten base positions read 00 in out_seq.
- in_char and in_last are ignored whenever the beat is not accepted. in_valid may drop mid-sequence; cnt holds.
- out_ready is ignored in FILL.
- Reset (reset=0), at any time including mid-FILL or mid-HOLD, asynchronously forces:
  - state=FILL, cnt=0.
  - out_seq=0, out_len=0, out_err=0.
  - out_valid=0, busy=0.
  - in_ready=0 while reset is asserted; in_ready=1 from the first edge after release.
- No partial sequence survives reset. A held sequence is dropped.
- cnt width is LW. cnt never exceeds LEN-1 in FILL; there is no wrap-around.

Test Plan:
- LEN=8, CH=3. Stream "ATCGCGA" on ch0, "ATCCCAA" on ch1, "AATCCGA" on ch2, with in_last on the 7th beat.
  - Expected: out_len=7; ch0 codes 00,01,11,10,11,10,00,00; out_err=000; out_valid rises one cycle after beat 7.
- Eight beats with no in_last.
  - Expected: HOLD after beat 8; out_len=8; in_ready=0.
  - Extra in_valid beats while HOLD with out_ready=0 are not accepted; outputs stay stable for 10 cycles.
- ch1 char 'N' at base 2 and lowercase 'g' at base 3.
  - Expected: out_seq ch1 base2=00, base3=10; out_err=010.
  - out_err clears after the out_ready handshake.
- Single beat with in_last=1.
  - Expected: out_len=1; bases 1..7 read 00.
  - out_ready held high: out_valid lasts exactly one cycle; in_ready=1 the next cycle.
- Drive reset=0 mid-FILL after 4 beats, then release and stream 3 beats with in_last.
  - Expected: out_len=3; no data from the earlier beats appears.
  - Repeat with reset applied during HOLD: out_valid drops immediately (asynchronously).
